// File: rtl/tcm_arb.sv
// Round-robin arbiter sharing one single-port TCM SRAM between
// instruction fetch (p0) and load/store (p1), one transaction in flight.
module tcm_arb #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int RAM_AW = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [AW-1:0]     p0_req_addr,
  input  logic              p0_req_we,
  input  logic [MW-1:0]     p0_req_wem,
  input  logic [DW-1:0]     p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DW-1:0]     p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [AW-1:0]     p1_req_addr,
  input  logic              p1_req_we,
  input  logic [MW-1:0]     p1_req_wem,
  input  logic [DW-1:0]     p1_req_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DW-1:0]     p1_rsp_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [MW-1:0]     ram_wem,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t              state;
  state_t              state_nx;
  logic                owner;
  logic                last_grant;
  logic [RAM_AW-1:0]   lat_addr;
  logic                lat_we;

  logic                hs;
  logic                slot;
  logic                grant;
  logic                accept;
  logic [RAM_AW-1:0]   sel_addr;
  logic                sel_we;
  logic [MW-1:0]       sel_wem;
  logic [DW-1:0]       sel_wdata;

  // Word index only; byte offset and high bits are don't-care.
  logic unused_addr;
  assign unused_addr = ^{p0_req_addr, p1_req_addr};

  always_comb begin
    grant = 1'b0;
    priority case (1'b1)
      (p0_req_valid && p1_req_valid): grant = ~last_grant;
      p1_req_valid:                   grant = 1'b1;
      default:                        grant = 1'b0;
    endcase
  end

  always_comb begin
    hs = (state == RESP) &&
         (owner ? p1_rsp_ready : p0_rsp_ready);
    slot   = !rst && ((state == IDLE) || hs);
    accept = slot && (p0_req_valid || p1_req_valid);
  end

  always_comb begin
    sel_addr  = grant ? p1_req_addr[RAM_AW+1:2]
                      : p0_req_addr[RAM_AW+1:2];
    sel_we    = grant ? p1_req_we    : p0_req_we;
    sel_wem   = grant ? p1_req_wem   : p0_req_wem;
    sel_wdata = grant ? p1_req_wdata : p0_req_wdata;
  end

  always_comb begin
    state_nx     = state;
    p0_req_ready = 1'b0;
    p1_req_ready = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    p0_rsp_rdata = '0;
    p1_rsp_rdata = '0;
    ram_addr     = '0;
    ram_we       = 1'b0;
    ram_wem      = '0;
    ram_din      = '0;

    if (state == RESP) begin
      // Re-present the latched address so ram_dout holds.
      ram_addr = lat_addr;
      if (owner) begin
        p1_rsp_valid = 1'b1;
        p1_rsp_rdata = lat_we ? '0 : ram_dout;
      end else begin
        p0_rsp_valid = 1'b1;
        p0_rsp_rdata = lat_we ? '0 : ram_dout;
      end
      if (hs) state_nx = IDLE;
    end

    if (accept) begin
      p0_req_ready = !grant;
      p1_req_ready = grant;
      ram_addr     = sel_addr;
      ram_we       = sel_we;
      ram_wem      = sel_wem;
      ram_din      = sel_wdata;
      state_nx     = RESP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        lat_addr   <= sel_addr;
        lat_we     <= sel_we;
      end
    end
  end

endmodule

// File: doc/tcm_arb.md
TCM_ARB -- requirements
Module: tcm_arb

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width of requester ports.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MW, default 4, byte write-mask width (DW/8).
REQ-004 SHALL have parameter RAM_AW, default 9, word-address width driven to the SRAM.
REQ-005 SHALL have a single clock: clk  in  1  rising-edge clock.
REQ-006 SHALL have reset rst  in  1; reset is asynchronous and active-high.
REQ-007 Ports p0_* (instruction fetch) and p1_* (load/store) SHALL each have: pN_req_valid in 1; pN_req_ready out 1; pN_req_addr in AW, byte address; pN_req_we in 1; pN_req_wem in MW; pN_req_wdata in DW; pN_rsp_valid out 1; pN_rsp_ready in 1; pN_rsp_rdata out DW.
REQ-008 SHALL have SRAM ports ram_addr out RAM_AW; ram_we out 1; ram_wem out MW; ram_din out DW; ram_dout in DW.

Function
REQ-009 SHALL share one single-port SRAM with 1-cycle read latency between p0 and p1: read address registered when ram_we=0; ram_dout holds while the address is re-presented.
REQ-010 SHALL implement states IDLE and RESP; at most one transaction outstanding.
REQ-011 Accept slot SHALL be open when state=IDLE, or state=RESP and the owner's rsp handshake (rsp_valid & rsp_ready) occurs this cycle.
REQ-012 In an open slot, only the granted port SHALL see req_ready=1; the other port SHALL see 0; with no open slot both SHALL see 0.
REQ-013 Grant: one valid port wins; both valid -> port not recorded in last_grant wins (round-robin); last_grant updated only on acceptance.
REQ-014 On acceptance in cycle T: ram_addr=req_addr[RAM_AW+1:2], ram_we=req_we, ram_wem=req_wem, ram_din=req_wdata in T; owner and addr latched; state->RESP at T+1.
REQ-015 In RESP with no acceptance: ram_we=0, ram_addr=latched addr, ram_wem=0, so ram_dout stays stable.
REQ-016 In RESP: owner's rsp_valid=1, rsp_rdata=ram_dout (reads); for writes rsp_rdata SHALL be 0; non-owner rsp_valid=0, rsp_rdata=0.
REQ-017 Response SHALL hold unchanged until rsp_ready=1; handshake without new acceptance -> IDLE next cycle.
REQ-018 Handshake with acceptance in same cycle -> stay RESP, new owner; sustains one transaction per cycle.
REQ-019 In IDLE with no request: ram_we=0, ram_wem=0, ram_addr=0, ram_din=0.
REQ-020 Address bits [1:0] and bits above RAM_AW+1 SHALL be ignored; no range checking.
REQ-021 Write acceptance SHALL not disturb the SRAM read register; a write never returns stale read data (rdata forced 0).

Reset
REQ-022 rst=1 SHALL asynchronously force state=IDLE, last_grant=1 (p0 wins first tie), owner=0, latched addr=0, latched we=0.
REQ-023 During and after reset: all rsp_valid=0, all req_ready=0 while rst=1, ram_we=0.
REQ-024 Reset mid-transaction SHALL drop the pending response; no rsp_valid after release until a new acceptance.

Verification
REQ-025 Reset release, p0 read addr 0x4 (mem[1]=0x0000_00B7), rsp_ready=1 -> p0_req_ready=1 cycle T, p0_rsp_valid=1 at T+1 with rdata=0x0000_00B7, IDLE at T+2.
REQ-026 p0 and p1 both valid continuously, rsp_ready=1 -> grants alternate p0,p1,p0,p1 on consecutive cycles; one response per cycle to correct port.
REQ-027 p1 write addr 0x8 wem=4'b0001 wdata=0xFFFF_FFAA over mem 0x0000_0101, then p1 read 0x8 -> write rsp rdata=0, read rdata=0x0000_01AA.
REQ-028 p0 read, p0_rsp_ready=0 for 5 cycles with p1_req_valid=1 -> p0_rsp_valid and rdata stable 5 cycles, ram_we=0, p1_req_ready=0; p1 accepted in the cycle p0_rsp_ready rises.
REQ-029 rst pulsed while in RESP -> rsp_valid falls immediately, state IDLE, first post-reset tie granted to p0.
